// File: rtl/bmw_op_sched.sv
// -----------------------------------------------------------------------------
// bmw_op_sched -- command scheduler in front of the BMW PIFO tree engines.
//
// Takes host push/pop commands one per handshake, and issues at most one tree
// operation at a time to the push or the pop engine, because both engines share
// the per-level SRAM banks. The block keeps its own occupancy count. It rejects
// a push when the tree is full and answers a pop on an empty tree directly, so
// neither case reaches an engine. Pop results come back from the pop engine
// after POP_LAT cycles; the block registers them and returns them to the host.
//
// Optional feature: define BMW_SCHED_STATS_EN to add saturating 32-bit
// counters for issued pushes, issued pops and rejections, with a clear input.
//
// Ports:
//   i_clk, i_arst      clock, asynchronous active-high reset
//   i_cmd_valid/op/data host command (op 0 = push, 1 = pop), o_cmd_ready
//   o_rsp_valid/data/empty  one-cycle pop response, data held between pulses
//   o_err_full         one-cycle pulse when a push is rejected (tree full)
//   o_push/o_push_data push strobe and value to the push engine, i_push_ready
//   o_pop, i_pop_ready, i_pop_data  pop strobe, engine idle, engine result
//   o_count            current occupancy
//   i_stat_clr, o_stat_push/pop/rej  (BMW_SCHED_STATS_EN only)
// -----------------------------------------------------------------------------
module bmw_op_sched #(
   parameter int PTW     = 16,
   parameter int MTW     = 0,
   parameter int CAP     = 21844,
   parameter int POP_LAT = 2,
   parameter int CNTW    = $clog2(CAP + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic                 i_cmd_valid,
   input  logic                 i_cmd_op,
   input  logic [MTW+PTW-1:0]   i_cmd_data,
   output logic                 o_cmd_ready,
   output logic                 o_rsp_valid,
   output logic [MTW+PTW-1:0]   o_rsp_data,
   output logic                 o_rsp_empty,
   output logic                 o_err_full,
   output logic                 o_push,
   output logic [MTW+PTW-1:0]   o_push_data,
   input  logic                 i_push_ready,
   output logic                 o_pop,
   input  logic                 i_pop_ready,
   input  logic [MTW+PTW-1:0]   i_pop_data,
   output logic [CNTW-1:0]      o_count
`ifdef BMW_SCHED_STATS_EN
   ,
   input  logic                 i_stat_clr,
   output logic [31:0]          o_stat_push,
   output logic [31:0]          o_stat_pop,
   output logic [31:0]          o_stat_rej
`endif
);

   localparam int              DW    = MTW + PTW;
   localparam logic [CNTW-1:0] CAP_C = CNTW'(CAP);
   localparam logic [3:0]      LAT_C = 4'(POP_LAT);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_PUSH = 2'd2,
      S_WAIT_POP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              op_q, op_d;              // 1 = operation in flight is a pop
   logic [3:0]        lat_q, lat_d;            // cycles left until pop data is captured
   logic [CNTW-1:0]   count_q, count_d;
   logic              push_q, push_d;
   logic [DW-1:0]     push_data_q, push_data_d;
   logic              pop_q, pop_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_data_q, rsp_data_d;
   logic              rsp_empty_q, rsp_empty_d;
   logic              err_full_q, err_full_d;
   logic              accept_s;

   assign o_cmd_ready = (state_q == S_IDLE) & i_push_ready & i_pop_ready;
   assign accept_s    = i_cmd_valid & o_cmd_ready;

   // Next-state and registered-output computation for the scheduler FSM
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lat_d       = lat_q;
      count_d     = count_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      pop_d       = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_empty_d = 1'b0;
      err_full_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               if (i_cmd_op == 1'b0) begin
                  if (count_q == CAP_C) begin
                     err_full_d = 1'b1;
                  end else begin
                     push_d      = 1'b1;
                     push_data_d = i_cmd_data;
                     count_d     = count_q + CNTW'(1);
                     op_d        = 1'b0;
                     state_d     = S_ISSUE;
                  end
               end else begin
                  if (count_q == {CNTW{1'b0}}) begin
                     rsp_valid_d = 1'b1;
                     rsp_empty_d = 1'b1;
                     rsp_data_d  = {DW{1'b1}};
                  end else begin
                     pop_d   = 1'b1;
                     count_d = count_q - CNTW'(1);
                     op_d    = 1'b1;
                     lat_d   = LAT_C;
                     state_d = S_ISSUE;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ISSUE: begin
            if (op_q) begin
               state_d = S_WAIT_POP;
               // With POP_LAT=1 the result is already due at the end of the issue cycle.
               if (lat_q == 4'd1) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = i_pop_data;
                  lat_d       = 4'd0;
               end else if (lat_q != 4'd0) begin
                  lat_d = lat_q - 4'd1;
               end else begin
                  lat_d = lat_q;
               end
            end else begin
               state_d = S_WAIT_PUSH;
            end
         end

         S_WAIT_PUSH: begin
            if (i_push_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_PUSH;
            end
         end

         S_WAIT_POP: begin
            if (lat_q == 4'd1) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = i_pop_data;
               lat_d       = 4'd0;
            end else if (lat_q != 4'd0) begin
               lat_d = lat_q - 4'd1;
            end else begin
               lat_d = lat_q;
            end
            // lat_q==0 here means the result has already been captured.
            if ((lat_q == 4'd0) && i_pop_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_POP;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q     <= S_IDLE;
         op_q        <= 1'b0;
         lat_q       <= 4'd0;
         count_q     <= {CNTW{1'b0}};
         push_q      <= 1'b0;
         push_data_q <= {DW{1'b0}};
         pop_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {DW{1'b1}};
         rsp_empty_q <= 1'b0;
         err_full_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lat_q       <= lat_d;
         count_q     <= count_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         pop_q       <= pop_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_empty_q <= rsp_empty_d;
         err_full_q  <= err_full_d;
      end
   end

   assign o_push      = push_q;
   assign o_push_data = push_data_q;
   assign o_pop       = pop_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_empty = rsp_empty_q;
   assign o_err_full  = err_full_q;
   assign o_count     = count_q;

`ifdef BMW_SCHED_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
      logic [31:0] r;
      if (inc && (v != 32'hFFFF_FFFF)) begin
         r = v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   logic [31:0] stat_push_q, stat_push_d;
   logic [31:0] stat_pop_q, stat_pop_d;
   logic [31:0] stat_rej_q, stat_rej_d;

   // Statistics update: clear wins over a same-cycle increment
   always_comb begin
      stat_push_d = stat_push_q;
      stat_pop_d  = stat_pop_q;
      stat_rej_d  = stat_rej_q;
      if (i_stat_clr) begin
         stat_push_d = 32'd0;
         stat_pop_d  = 32'd0;
         stat_rej_d  = 32'd0;
      end else begin
         stat_push_d = sat_inc(stat_push_q, push_d);
         stat_pop_d  = sat_inc(stat_pop_q, pop_d);
         stat_rej_d  = sat_inc(stat_rej_q, err_full_d | (rsp_valid_d & rsp_empty_d));
      end
   end

   // Statistics registers
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         stat_push_q <= 32'd0;
         stat_pop_q  <= 32'd0;
         stat_rej_q  <= 32'd0;
      end else begin
         stat_push_q <= stat_push_d;
         stat_pop_q  <= stat_pop_d;
         stat_rej_q  <= stat_rej_d;
      end
   end

   assign o_stat_push = stat_push_q;
   assign o_stat_pop  = stat_pop_q;
   assign o_stat_rej  = stat_rej_q;
`endif

endmodule

// File: tb/tb_bmw_op_sched.sv
// -----------------------------------------------------------------------------
// Testbench for bmw_op_sched (CAP=4, POP_LAT=2). The bench models the tree as
// a FIFO of pushed values and plays the pop engine from it. Expected responses
// are queued when a pop is issued and compared when o_rsp_valid pulses.
// -----------------------------------------------------------------------------
module tb_bmw_op_sched;
   localparam int PTW     = 16;
   localparam int MTW     = 0;
   localparam int CAP     = 4;
   localparam int POP_LAT = 2;
   localparam int DW      = MTW + PTW;
   localparam int CNTW    = $clog2(CAP + 1);

   logic            clk = 1'b0;
   logic            i_arst;
   logic            i_cmd_valid;
   logic            i_cmd_op;
   logic [DW-1:0]   i_cmd_data;
   logic            o_cmd_ready;
   logic            o_rsp_valid;
   logic [DW-1:0]   o_rsp_data;
   logic            o_rsp_empty;
   logic            o_err_full;
   logic            o_push;
   logic [DW-1:0]   o_push_data;
   logic            i_push_ready;
   logic            o_pop;
   logic            i_pop_ready;
   logic [DW-1:0]   i_pop_data;
   logic [CNTW-1:0] o_count;
`ifdef BMW_SCHED_STATS_EN
   logic            i_stat_clr;
   logic [31:0]     o_stat_push;
   logic [31:0]     o_stat_pop;
   logic [31:0]     o_stat_rej;
`endif

   int errors = 0;
   int checks = 0;
   logic [DW:0]   sb_q[$];    // expected {empty, data} responses
   logic [DW-1:0] tree_q[$];  // model tree contents

   always #5 clk = ~clk;

   bmw_op_sched #(.PTW(PTW), .MTW(MTW), .CAP(CAP), .POP_LAT(POP_LAT)) dut (
      .i_clk(clk), .i_arst(i_arst),
      .i_cmd_valid(i_cmd_valid), .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
      .o_cmd_ready(o_cmd_ready),
      .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_empty(o_rsp_empty),
      .o_err_full(o_err_full),
      .o_push(o_push), .o_push_data(o_push_data), .i_push_ready(i_push_ready),
      .o_pop(o_pop), .i_pop_ready(i_pop_ready), .i_pop_data(i_pop_data),
      .o_count(o_count)
`ifdef BMW_SCHED_STATS_EN
      , .i_stat_clr(i_stat_clr), .o_stat_push(o_stat_push),
      .o_stat_pop(o_stat_pop), .o_stat_rej(o_stat_rej)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command, wait for acceptance, return at cycle t+1 (+1ns).
   task automatic issue(input logic op, input logic [DW-1:0] data, output int waited);
      logic [DW-1:0] v;
      i_cmd_valid = 1'b1;
      i_cmd_op    = op;
      i_cmd_data  = data;
      #1;
      waited = 0;
      while (o_cmd_ready !== 1'b1 && waited < 50) begin
         @(posedge clk);
         #2;
         waited++;
      end
      checks++;
      if (o_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: o_cmd_ready=%b required 1", o_cmd_ready);
      end
      v = {DW{1'b0}};
      if (op == 1'b1) begin
         if (tree_q.size() == 0) begin
            sb_q.push_back({1'b1, {DW{1'b1}}});
         end else begin
            v = tree_q.pop_front();
            sb_q.push_back({1'b0, v});
         end
      end else if (tree_q.size() < CAP) begin
         tree_q.push_back(data);
      end
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
      if (op == 1'b1) i_pop_data = v;  // pop engine presents its result
   endtask

   // Wait for the pop response and compare it with the scoreboard.
   task automatic wait_rsp(input int exp_lat);
      int n;
      logic [DW:0] e;
      n = 0;
      while (o_rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (o_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL rsp_timeout: o_rsp_valid=%b required 1", o_rsp_valid);
      end else begin
         checks++;
         if (n != exp_lat) begin
            errors++;
            $display("FAIL rsp_latency: got %0d cycles after t+1, required %0d", n, exp_lat);
         end
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: response with empty scoreboard");
         end else begin
            e = sb_q.pop_front();
            if ({o_rsp_empty, o_rsp_data} !== e) begin
               errors++;
               $display("FAIL rsp_data: got empty=%b data=%h required empty=%b data=%h",
                        o_rsp_empty, o_rsp_data, e[DW], e[DW-1:0]);
            end
         end
      end
      i_pop_data = 16'hDEAD;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (o_cmd_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (o_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_timeout: o_cmd_ready=%b required 1", o_cmd_ready);
      end
   endtask

   task automatic test_reset();
      i_arst = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = 1'b0; i_cmd_data = 16'h0000;
      i_push_ready = 1'b1; i_pop_ready = 1'b1; i_pop_data = 16'hDEAD;
`ifdef BMW_SCHED_STATS_EN
      i_stat_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({o_count, o_push, o_pop, o_rsp_valid, o_rsp_empty, o_err_full} !== '0) begin
         errors++;
         $display("FAIL reset_ctl: count=%0d push=%b pop=%b rv=%b re=%b ef=%b required all 0",
                  o_count, o_push, o_pop, o_rsp_valid, o_rsp_empty, o_err_full);
      end
      checks++;
      if (o_rsp_data !== 16'hFFFF) begin
         errors++; $display("FAIL reset_rsp_data: got %h required ffff", o_rsp_data);
      end
      checks++;
      if (o_push_data !== 16'h0000) begin
         errors++; $display("FAIL reset_push_data: got %h required 0000", o_push_data);
      end
`ifdef BMW_SCHED_STATS_EN
      checks++;
      if ({o_stat_push, o_stat_pop, o_stat_rej} !== 96'd0) begin
         errors++; $display("FAIL reset_stats: got %0d/%0d/%0d required 0", o_stat_push, o_stat_pop, o_stat_rej);
      end
`endif
      i_arst = 1'b0;
      tick();
      checks++;
      if (o_cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b required 1", o_cmd_ready);
      end
   endtask

   task automatic test_empty_pop();
      int w;
      issue(1'b1, 16'h1234, w);
      checks++;
      if (o_pop !== 1'b0 || o_count !== 3'd0) begin
         errors++; $display("FAIL empty_pop_nopop: pop=%b count=%0d required 0/0", o_pop, o_count);
      end
      wait_rsp(0);
      tick();
      checks++;
      if (o_rsp_valid !== 1'b0 || o_pop !== 1'b0) begin
         errors++; $display("FAIL empty_pop_pulse: rv=%b pop=%b required 0/0", o_rsp_valid, o_pop);
      end
   endtask

   task automatic test_push();
      int w;
      issue(1'b0, 16'h0005, w);
      i_push_ready = 1'b0;
      checks++;
      if (o_push !== 1'b1 || o_push_data !== 16'h0005 || o_count !== 3'd1) begin
         errors++; $display("FAIL push_issue: push=%b data=%h count=%0d required 1/0005/1",
                            o_push, o_push_data, o_count);
      end
      tick();
      checks++;
      if (o_push !== 1'b0) begin
         errors++; $display("FAIL push_pulse: push=%b required 0", o_push);
      end
      tick();
      i_push_ready = 1'b1;
      #1;
      checks++;
      if (o_cmd_ready !== 1'b0) begin
         errors++; $display("FAIL push_wait_ready: ready=%b required 0 in WAIT_PUSH", o_cmd_ready);
      end
      tick();
      checks++;
      if (o_cmd_ready !== 1'b1) begin
         errors++; $display("FAIL push_done_ready: ready=%b required 1", o_cmd_ready);
      end
   endtask

   task automatic test_push_pop();
      int w, n;
      issue(1'b1, 16'h0000, w);           // drain 0x0005
      wait_rsp(POP_LAT);
      wait_ready(n);
      issue(1'b0, 16'h0007, w);
      wait_ready(n);
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL push_spacing: got %0d required 2", n);
      end
      issue(1'b1, 16'h0000, w);
      checks++;
      if (o_pop !== 1'b1 || o_count !== 3'd0) begin
         errors++; $display("FAIL pop_issue: pop=%b count=%0d required 1/0", o_pop, o_count);
      end
      wait_rsp(POP_LAT);
      wait_ready(n);
      checks++;
      if (n != 1) begin
         errors++; $display("FAIL pop_spacing: got %0d required 1", n);
      end
   endtask

   task automatic test_cap_limit();
      int w, n;
      for (int i = 0; i < CAP; i++) begin
         issue(1'b0, 16'($urandom_range(0, 16'hFFFE)), w);
         wait_ready(n);
      end
      issue(1'b0, 16'h0BAD, w);
      checks++;
      if (o_err_full !== 1'b1 || o_push !== 1'b0 || o_count !== 3'd4 || o_cmd_ready !== 1'b1) begin
         errors++; $display("FAIL full_reject: ef=%b push=%b count=%0d ready=%b required 1/0/4/1",
                            o_err_full, o_push, o_count, o_cmd_ready);
      end
      tick();
      checks++;
      if (o_err_full !== 1'b0) begin
         errors++; $display("FAIL full_pulse: ef=%b required 0", o_err_full);
      end
      for (int i = 0; i < CAP; i++) begin
         issue(1'b1, 16'h0000, w);
         wait_rsp(POP_LAT);
         wait_ready(n);
      end
      issue(1'b1, 16'h0000, w);
      wait_rsp(0);
      checks++;
      if (o_count !== 3'd0) begin
         errors++; $display("FAIL cap_drain_count: got %0d required 0", o_count);
      end
   endtask

   task automatic test_pop_ready_hold();
      int w, n;
      issue(1'b0, 16'h00A5, w);
      wait_ready(n);
      issue(1'b1, 16'h0000, w);
      i_pop_ready = 1'b0;
      wait_rsp(POP_LAT);
      repeat (5) begin
         tick();
         checks++;
         if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b0) begin
            errors++; $display("FAIL hold_wait: rv=%b ready=%b required 0/0", o_rsp_valid, o_cmd_ready);
         end
      end
      i_pop_ready = 1'b1;
      #1;
      checks++;
      if (o_cmd_ready !== 1'b0) begin
         errors++; $display("FAIL hold_release: ready=%b required 0 while in WAIT_POP", o_cmd_ready);
      end
      tick();
      issue(1'b0, 16'h0033, w);
      checks++;
      if (w != 0 || o_push !== 1'b1 || o_push_data !== 16'h0033) begin
         errors++; $display("FAIL hold_next_cmd: waited=%0d push=%b data=%h required 0/1/0033",
                            w, o_push, o_push_data);
      end
      wait_ready(n);
   endtask

   task automatic test_reset_midop();
      int w, n;
      issue(1'b0, 16'h0044, w);
      wait_ready(n);
      issue(1'b1, 16'h0000, w);            // pops 0x0033, count 1
      i_pop_ready = 1'b0;
      wait_rsp(POP_LAT);
      #2;
      i_arst = 1'b1;
      #1;
      checks++;
      if (o_rsp_valid !== 1'b0 || o_count !== 3'd0 || o_rsp_data !== 16'hFFFF || o_pop !== 1'b0) begin
         errors++; $display("FAIL reset_waitpop: rv=%b count=%0d data=%h pop=%b required 0/0/ffff/0",
                            o_rsp_valid, o_count, o_rsp_data, o_pop);
      end
`ifdef BMW_SCHED_STATS_EN
      checks++;
      if ({o_stat_push, o_stat_pop, o_stat_rej} !== 96'd0) begin
         errors++; $display("FAIL reset_midop_stats: got %0d/%0d/%0d required 0", o_stat_push, o_stat_pop, o_stat_rej);
      end
`endif
      @(posedge clk);
      #1;
      i_arst = 1'b0;
      i_pop_ready = 1'b1;
      tree_q.delete();
      sb_q.delete();
      tick();
      issue(1'b0, 16'h0055, w);
      #2;
      i_arst = 1'b1;
      #1;
      checks++;
      if (o_push !== 1'b0 || o_count !== 3'd0 || o_push_data !== 16'h0000) begin
         errors++; $display("FAIL reset_push: push=%b count=%0d data=%h required 0/0/0000",
                            o_push, o_count, o_push_data);
      end
      @(posedge clk);
      #1;
      i_arst = 1'b0;
      tree_q.delete();
      tick();
   endtask

`ifdef BMW_SCHED_STATS_EN
   task automatic test_stat_clr();
      int w, n;
      issue(1'b0, 16'h0066, w);
      wait_ready(n);
      checks++;
      if (o_stat_push !== 32'd1) begin
         errors++; $display("FAIL stat_push: got %0d required 1", o_stat_push);
      end
      i_stat_clr = 1'b1;
      issue(1'b1, 16'h0000, w);
      i_stat_clr = 1'b0;
      checks++;
      if (o_stat_pop !== 32'd0 || o_stat_push !== 32'd0) begin
         errors++; $display("FAIL stat_clr: pop=%0d push=%0d required 0/0", o_stat_pop, o_stat_push);
      end
      wait_rsp(POP_LAT);
      wait_ready(n);
   endtask
`endif

   initial begin
      test_reset();
      test_empty_pop();
      test_push();
      test_push_pop();
      test_cap_limit();
      test_pop_ready_hold();
      test_reset_midop();
`ifdef BMW_SCHED_STATS_EN
      test_stat_clr();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
